// File: rtl/sap_pkg.sv
// Shared arbiter definitions: FSM state encoding and port identifiers.
// Imported by the arbiter top and its round-robin picker.
package sap_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-port round-robin winner select, purely combinational (zero latency).
// A lone eligible port wins; on a tie the port not granted last wins.
module rr_pick2
  import sap_pkg::*;
(
  input  logic [1:0] eligible_i,
  input  logic       last_i,
  output logic       winner_o
);

  always_comb begin
    winner_o = PORT_CPU;
    unique case (eligible_i)
      2'b01:   winner_o = PORT_CPU;
      2'b10:   winner_o = PORT_HOST;
      2'b11:   winner_o = ~last_i;
      default: winner_o = last_i;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between a CPU and a host loader; grant edge -> ack next cycle.
// Ports hold req until ack; losers wait. host_lock fences the CPU off without aborting its access.
module ram_arbiter
  import sap_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic          host_ack_o,
  output logic [DW-1:0] host_rdata_o,
  input  logic          host_lock_i,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          owner_o,
  output logic          busy_o
);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          access;
  logic [1:0]    eligible;
  logic          winner;

  rr_pick2 u_pick (
    .eligible_i (eligible),
    .last_i     (last_q),
    .winner_o   (winner)
  );

  // Reset in the access cycle kills the ack and the write strobe immediately.
  always_comb begin
    access       = (state_q == ST_ACCESS);
    cpu_ack_o    = access && (owner_q == PORT_CPU)  && !rst_i;
    host_ack_o   = access && (owner_q == PORT_HOST) && !rst_i;
    cpu_rdata_o  = cpu_ack_o  ? ram_rdata_i : '0;
    host_rdata_o = host_ack_o ? ram_rdata_i : '0;
    eligible     = {host_req_i && !host_ack_o,
                    cpu_req_i && !host_lock_i && !cpu_ack_o};
  end

  always_comb begin
    state_d = ST_IDLE;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (|eligible) begin
      state_d = ST_ACCESS;
      owner_d = winner;
      last_d  = winner;
      if (winner == PORT_HOST) begin
        we_d    = host_we_i;
        addr_d  = host_addr_i;
        wdata_d = host_wdata_i;
      end else begin
        we_d    = cpu_we_i;
        addr_d  = cpu_addr_i;
        wdata_d = cpu_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_CPU;
      last_q  <= PORT_HOST;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ram_we_o    = we_q && access && !rst_i;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign owner_o     = owner_q;
  assign busy_o      = access;

endmodule
